// File: rtl/rou_req_arb_if.sv
// rou_req_arb_if: request, nif and response signals of rou_req_arb.
// slave is the arbiter's view; master is the requester/nif side facing it.
interface rou_req_arb_if #(
  parameter int DWID = 128,
  parameter int AWID = 32,
  parameter int TWID = 5,
  parameter int BWID = 4,
  parameter int NREQ = 4,
  parameter int WID  = 2 + DWID + AWID + BWID + TWID
);
  logic [NREQ-1:0]     req_vld;
  logic [NREQ*WID-1:0] req_msg;
  logic [NREQ-1:0]     req_ack;
  logic [WID-1:0]      msg_out;
  logic                msg_out_ack;
  logic [WID-1:0]      msg_in;
  logic                msg_in_ack;
  logic [WID-1:0]      rsp_msg;
  logic [NREQ-1:0]     rsp_vld;
  logic [NREQ-1:0]     rsp_ack;
  logic                busy;
  logic [7:0]          err_cnt;

  modport slave (
    input  req_vld, req_msg, msg_out_ack, msg_in, rsp_ack,
    output req_ack, msg_out, msg_in_ack, rsp_msg, rsp_vld, busy, err_cnt
  );

  modport master (
    output req_vld, req_msg, msg_out_ack, msg_in, rsp_ack,
    input  req_ack, msg_out, msg_in_ack, rsp_msg, rsp_vld, busy, err_cnt
  );
endinterface

// File: rtl/rou_req_arb.sv
// rou_req_arb: round-robin arbiter sharing one rou nif request port among NREQ
// local masters, plus a single-entry response buffer routed back by tag index.
module rou_req_arb #(
  parameter int DWID = 128,
  parameter int AWID = 32,
  parameter int TWID = 5,
  parameter int BWID = 4,
  parameter int NREQ = 4,
  parameter int IWID = 2,
  parameter int WID  = 2 + DWID + AWID + BWID + TWID
) (
  input logic          clk,
  input logic          rst,
  rou_req_arb_if.slave bus
);
  // Requester index lives in the top IWID bits of the tag, just below cmd.
  localparam int IDX_HI = WID - 3;

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t          state_r;
  logic [IWID-1:0] ptr_r;
  logic [IWID-1:0] gnt_r;
  logic [WID-1:0]  msg_out_r;
  logic [NREQ-1:0] req_ack_r;
  logic [WID-1:0]  rsp_msg_r;
  logic [NREQ-1:0] rsp_vld_r;
  logic            msg_in_ack_r;
  logic [7:0]      err_cnt_r;

  logic [IWID-1:0] nxt_ptr_s;
  logic [IWID-1:0] base_s;
  logic [IWID-1:0] win_s;
  logic [IWID:0]   pos_s;
  logic [NREQ-1:0] cand_s;
  logic            any_s;
  logic [WID-1:0]  sel_msg_s;
  logic [IWID-1:0] k_s;
  logic            k_ok_s;
  logic            in_vld_s;
  logic            rel_s;
  logic            cap_s;

  function automatic logic [NREQ-1:0] onehot(input logic [IWID-1:0] idx);
    logic [NREQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      oh[i] = (idx == IWID'(i));
    end
    return oh;
  endfunction

  // Pointer value following the current grant, wrapping at NREQ.
  always_comb begin
    if (gnt_r == IWID'(NREQ - 1)) begin
      nxt_ptr_s = '0;
    end else begin
      nxt_ptr_s = gnt_r + IWID'(1);
    end
  end

  // Round-robin search from base; a requester being acked this cycle is skipped.
  always_comb begin
    base_s    = (state_r == SEND) ? nxt_ptr_s : ptr_r;
    cand_s    = bus.req_vld & ~req_ack_r;
    any_s     = 1'b0;
    win_s     = '0;
    pos_s     = '0;
    sel_msg_s = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      pos_s = {1'b0, base_s} + (IWID + 1)'(i);
      pos_s = (pos_s >= (IWID + 1)'(NREQ)) ? pos_s - (IWID + 1)'(NREQ) : pos_s;
      any_s = any_s | cand_s[pos_s[IWID-1:0]];
      win_s = cand_s[pos_s[IWID-1:0]] ? pos_s[IWID-1:0] : win_s;
    end
    for (int i = 0; i < NREQ; i++) begin
      sel_msg_s = (win_s == IWID'(i)) ? bus.req_msg[i*WID +: WID] : sel_msg_s;
    end
    sel_msg_s[IDX_HI -: IWID] = win_s;
  end

  // Response capture decode; the cycle after an ack the nif is replacing msg_in.
  always_comb begin
    k_s      = bus.msg_in[IDX_HI -: IWID];
    k_ok_s   = ({1'b0, k_s} < (IWID + 1)'(NREQ));
    in_vld_s = (bus.msg_in[WID-1 -: 2] != 2'b00);
    rel_s    = |(rsp_vld_r & bus.rsp_ack);
    cap_s    = in_vld_s & ~msg_in_ack_r & (~(|rsp_vld_r) | rel_s);
  end

  // Request path FSM: grant, hold until consumed, chain the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      ptr_r     <= '0;
      gnt_r     <= '0;
      msg_out_r <= '0;
      req_ack_r <= '0;
    end else begin
      req_ack_r <= '0;
      case (state_r)
        IDLE: begin
          if (any_s) begin
            msg_out_r <= sel_msg_s;
            req_ack_r <= onehot(win_s);
            gnt_r     <= win_s;
            state_r   <= SEND;
          end
        end
        SEND: begin
          if (bus.msg_out_ack) begin
            ptr_r <= nxt_ptr_s;
            if (any_s) begin
              msg_out_r <= sel_msg_s;
              req_ack_r <= onehot(win_s);
              gnt_r     <= win_s;
            end else begin
              msg_out_r <= '0;
              state_r   <= IDLE;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Response buffer: release by owner ack, capture, or drop with error count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_msg_r    <= '0;
      rsp_vld_r    <= '0;
      msg_in_ack_r <= 1'b0;
      err_cnt_r    <= 8'd0;
    end else begin
      msg_in_ack_r <= cap_s;
      if (rel_s) begin
        rsp_vld_r <= '0;
      end
      if (cap_s && k_ok_s) begin
        rsp_msg_r <= bus.msg_in;
        rsp_vld_r <= onehot(k_s);
      end
      if (cap_s && !k_ok_s && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end
    end
  end

  assign bus.req_ack    = req_ack_r;
  assign bus.msg_out    = msg_out_r;
  assign bus.msg_in_ack = msg_in_ack_r;
  assign bus.rsp_msg    = rsp_msg_r;
  assign bus.rsp_vld    = rsp_vld_r;
  assign bus.err_cnt    = err_cnt_r;
  assign bus.busy       = (msg_out_r[WID-1 -: 2] != 2'b00);
endmodule

// File: tb/tb_rou_req_arb.sv
// Bench for rou_req_arb: a 4-requester instance for arbitration and routing,
// a 3-requester instance for out-of-range response indices.
module tb_rou_req_arb;
  localparam int DWID   = 128;
  localparam int AWID   = 32;
  localparam int TWID   = 5;
  localparam int BWID   = 4;
  localparam int IWID   = 2;
  localparam int WID    = 2 + DWID + AWID + BWID + TWID;
  localparam int TAG_HI = WID - 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  typedef struct { logic [3:0] ack; logic [WID-1:0] msg; } exp_t;
  typedef struct { logic [1:0] idx; logic [2:0] vld; logic [7:0] err; } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  rou_req_arb_if #(.DWID(DWID), .AWID(AWID), .TWID(TWID), .BWID(BWID), .NREQ(4)) if4 ();
  rou_req_arb_if #(.DWID(DWID), .AWID(AWID), .TWID(TWID), .BWID(BWID), .NREQ(3)) if3 ();

  rou_req_arb #(.DWID(DWID), .AWID(AWID), .TWID(TWID), .BWID(BWID), .NREQ(4), .IWID(IWID))
    dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  rou_req_arb #(.DWID(DWID), .AWID(AWID), .TWID(TWID), .BWID(BWID), .NREQ(3), .IWID(IWID))
    dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  function automatic logic [WID-1:0] mk(input logic [1:0] cmd, input logic [TWID-1:0] tag,
                                        input logic [31:0] d);
    logic [BWID-1:0] b;
    logic [AWID-1:0] a;
    logic [DWID-1:0] dat;
    b   = 4'h5;
    a   = 32'h4000_0000 | d;
    dat = {4{d ^ 32'hA5A5_0000}};
    return {cmd, tag, b, a, dat};
  endfunction

  function automatic logic [WID-1:0] stamp(input logic [WID-1:0] m, input logic [IWID-1:0] i);
    logic [WID-1:0] r;
    r = m;
    r[TAG_HI -: IWID] = i;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int i, input logic [31:0] d);
    logic [WID-1:0] m;
    exp_t e;
    m = mk(2'b01, 5'h1F, d);
    if4.req_msg[i*WID +: WID] = m;
    if4.req_vld[i] = 1'b1;
    e.ack = 4'(1 << i);
    e.msg = stamp(m, IWID'(i));
    exp_q.push_back(e);
  endtask

  // Scoreboard: each grant pulse must match the oldest queued expectation.
  always begin
    @(posedge clk);
    #1;
    if (!rst && if4.req_ack != 4'b0000) begin
      chk("sb_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("sb_req_ack", if4.req_ack, mon_e.ack);
        chk("sb_msg_out", if4.msg_out, mon_e.msg);
      end
    end
  end

  initial begin
    int seq [4];
    int acks, cyc, cnt, bad;
    logic [WID-1:0] m1, m2, hold;
    vec_t vt [6];

    vt[0] = '{2'd0, 3'b001, 8'd0};
    vt[1] = '{2'd3, 3'b000, 8'd1};
    vt[2] = '{2'd1, 3'b010, 8'd1};
    vt[3] = '{2'd3, 3'b000, 8'd2};
    vt[4] = '{2'd2, 3'b100, 8'd2};
    vt[5] = '{2'd3, 3'b000, 8'd3};

    if4.req_vld = '0; if4.req_msg = '0; if4.msg_out_ack = 1'b0; if4.msg_in = '0; if4.rsp_ack = '0;
    if3.req_vld = '0; if3.req_msg = '0; if3.msg_out_ack = 1'b0; if3.msg_in = '0; if3.rsp_ack = '0;

    tick();
    tick();
    chk("rst_msg_out", if4.msg_out, 0);
    chk("rst_req_ack", if4.req_ack, 0);
    chk("rst_busy", if4.busy, 0);
    chk("rst_rsp_vld", if4.rsp_vld, 0);
    chk("rst_rsp_msg", if4.rsp_msg, 0);
    chk("rst_in_ack", if4.msg_in_ack, 0);
    chk("rst_err_cnt", if3.err_cnt, 0);
    rst = 1'b0;

    // Single request: index 0 stamped into tag 0x1F gives 0x07.
    if4.msg_out_ack = 1'b1;
    drive_req(0, 32'h11);
    tick();
    chk("single_ack", if4.req_ack, 4'b0001);
    chk("single_tag", if4.msg_out[TAG_HI -: TWID], 5'h07);
    chk("single_busy", if4.busy, 1'b1);
    if4.req_vld = '0;
    tick();
    chk("single_idle_msg", if4.msg_out, 0);
    chk("single_idle_busy", if4.busy, 0);
    chk("single_ack_pulse", if4.req_ack, 0);

    // Fairness: pointer now 1, so grants run 1,2,3,0 with no gaps.
    for (int i = 0; i < 4; i++) seq[i] = 0;
    for (int j = 1; j <= 4; j++) drive_req(j % 4, 32'h100 + 32'(j % 4));
    acks = 0;
    cyc  = 0;
    while (acks < 12 && cyc < 40) begin
      tick();
      cyc++;
      for (int i = 0; i < 4; i++) begin
        if (if4.req_ack[i]) begin
          acks++;
          if (seq[i] < 2) begin
            seq[i]++;
            drive_req(i, 32'h100 + 32'(seq[i] * 16 + i));
          end else begin
            if4.req_vld[i] = 1'b0;
          end
        end
      end
    end
    chk("fair_acks", acks, 12);
    chk("fair_cycles", cyc, 12);
    tick();
    chk("fair_idle", if4.msg_out, 0);

    // Backpressure: ten stalled cycles, then advance to requester 2.
    if4.msg_out_ack = 1'b0;
    drive_req(1, 32'h201);
    drive_req(2, 32'h202);
    hold = stamp(mk(2'b01, 5'h1F, 32'h201), 2'd1);
    tick();
    chk("bp_first_ack", if4.req_ack, 4'b0010);
    if4.req_vld[1] = 1'b0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (if4.msg_out === hold && if4.req_ack === 4'b0000) cnt++;
    end
    chk("bp_stable", cnt, 10);
    if4.msg_out_ack = 1'b1;
    tick();
    chk("bp_release_ack", if4.req_ack, 4'b0100);
    if4.req_vld[2] = 1'b0;
    tick();
    chk("bp_idle", if4.busy, 0);

    // Response routing to requester 2 with a second message waiting.
    m1 = mk(2'b01, 5'h13, 32'h301);
    m2 = mk(2'b10, 5'h0B, 32'h302);
    if4.msg_in = m1;
    tick();
    chk("rt_ack", if4.msg_in_ack, 1'b1);
    chk("rt_vld", if4.rsp_vld, 4'b0100);
    chk("rt_msg", if4.rsp_msg, m1);
    if4.msg_in  = m2;
    if4.rsp_ack = 4'b0010;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (if4.msg_in_ack === 1'b0 && if4.rsp_vld === 4'b0100) cnt++;
    end
    chk("rt_hold", cnt, 5);
    if4.rsp_ack = 4'b0100;
    tick();
    chk("rt2_ack", if4.msg_in_ack, 1'b1);
    chk("rt2_vld", if4.rsp_vld, 4'b0010);
    chk("rt2_msg", if4.rsp_msg, m2);
    if4.msg_in  = '0;
    if4.rsp_ack = 4'b0010;
    tick();
    chk("rt_empty", if4.rsp_vld, 0);
    if4.rsp_ack = '0;

    // Index table on the 3-requester instance; index 3 is dropped and counted.
    for (int v = 0; v < 6; v++) begin
      m1 = mk(2'b11, {vt[v].idx, 3'b101}, 32'h400 + 32'(v));
      if3.msg_in = m1;
      tick();
      chk($sformatf("tbl%0d_ack", v), if3.msg_in_ack, 1'b1);
      chk($sformatf("tbl%0d_vld", v), if3.rsp_vld, vt[v].vld);
      chk($sformatf("tbl%0d_err", v), if3.err_cnt, vt[v].err);
      if (vt[v].vld != 3'b000) chk($sformatf("tbl%0d_msg", v), if3.rsp_msg, m1);
      if3.msg_in  = '0;
      if3.rsp_ack = vt[v].vld;
      tick();
      chk($sformatf("tbl%0d_drain", v), if3.rsp_vld, 0);
      if3.rsp_ack = '0;
    end

    // 300 more bad-index messages saturate the error counter.
    acks = 0;
    cyc  = 0;
    bad  = 0;
    if3.msg_in = mk(2'b01, 5'h1C, 32'h500);
    while (acks < 300 && cyc < 1000) begin
      tick();
      cyc++;
      if (if3.rsp_vld !== 3'b000) bad++;
      if (if3.msg_in_ack === 1'b1) begin
        acks++;
        if3.msg_in = mk(2'b01, 5'h1C, 32'h500 + 32'(acks));
      end
    end
    if3.msg_in = '0;
    chk("sat_acks", acks, 300);
    chk("sat_err", if3.err_cnt, 8'd255);
    chk("sat_no_vld", bad, 0);

    // Asynchronous reset during SEND with a response held.
    if4.msg_out_ack = 1'b0;
    drive_req(3, 32'h601);
    if4.msg_in = mk(2'b01, 5'h0A, 32'h602);
    tick();
    chk("pre_rst_ack", if4.req_ack, 4'b1000);
    chk("pre_rst_vld", if4.rsp_vld, 4'b0010);
    if4.req_vld = '0;
    if4.msg_in  = '0;
    #2 rst = 1'b1;
    #1;
    chk("arst_msg_out", if4.msg_out, 0);
    chk("arst_busy", if4.busy, 0);
    chk("arst_req_ack", if4.req_ack, 0);
    chk("arst_in_ack", if4.msg_in_ack, 0);
    chk("arst_rsp_vld", if4.rsp_vld, 0);
    chk("arst_rsp_msg", if4.rsp_msg, 0);
    chk("arst_err_cnt", if3.err_cnt, 0);
    tick();
    rst = 1'b0;
    if4.msg_out_ack = 1'b1;
    drive_req(0, 32'h701);
    drive_req(3, 32'h703);
    tick();
    chk("post_rst_grant", if4.req_ack, 4'b0001);
    if4.req_vld[0] = 1'b0;
    tick();
    chk("post_rst_next", if4.req_ack, 4'b1000);
    if4.req_vld[3] = 1'b0;
    tick();
    chk("post_rst_idle", if4.busy, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
